// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if
//   Groups the digit-load bus and the display drive lines of seven_seg_scanner.
//   load_valid : one-cycle strobe capturing digits_in/dp_in/blink_in
//   digits_in  : four hex nibbles, [3:0] = rightmost position 0
//   dp_in      : decimal point per position, 1 lights it
//   blink_in   : blink mask per position, 1 enables blinking
//   an         : anode select, active-low
//   seg        : segments, active-low, seg[6:0] = g..a, seg[7] = dp
//   master modport drives the load bus and observes the display;
//   slave modport is the scanner side.
interface seven_seg_scanner_if;
    logic        load_valid;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blink_in;
    logic [3:0]  an;
    logic [7:0]  seg;

    modport master (
        output load_valid, digits_in, dp_in, blink_in,
        input  an, seg
    );

    modport slave (
        input  load_valid, digits_in, dp_in, blink_in,
        output an, seg
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed four-digit seven-segment driver. Digit loads land in a
//   pending set and are promoted to the displayed (active) set only on the
//   scan wrap 3 -> 0, so a frame never mixes old and new digits.
//   master_clk  : system clock, rising edge
//   rst         : synchronous active-high reset
//   clk_display : one-cycle scan-advance enable
//   clk_blink   : blink level; blanks masked digits while high
//   bus         : load bus in, an/seg out (seven_seg_scanner_if.slave)
//   frame_start : one-cycle pulse in the cycle after the wrap tick
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic               master_clk,
    input  logic               rst,
    input  logic               clk_display,
    input  logic               clk_blink,
    seven_seg_scanner_if.slave bus,
    output logic               frame_start
);

    localparam int unsigned POS_W = $clog2(NUM_DIGITS);

    logic [POS_W-1:0] pos, pos_nx;
    logic [15:0]      act_dig, act_dig_nx, pend_dig, pend_dig_nx;
    logic [3:0]       act_dp, act_dp_nx, pend_dp, pend_dp_nx;
    logic [3:0]       act_bl, act_bl_nx, pend_bl, pend_bl_nx;
    logic             pend_flag, pend_flag_nx;
    logic             wrap;
    logic             blank;
    logic [3:0]       digit;
    logic [3:0]       an_nx;
    logic [7:0]       seg_nx;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        wrap         = clk_display && (pos == POS_W'(NUM_DIGITS - 1));
        pos_nx       = clk_display ? pos + POS_W'(1) : pos;
        act_dig_nx   = act_dig;
        act_dp_nx    = act_dp;
        act_bl_nx    = act_bl;
        pend_dig_nx  = pend_dig;
        pend_dp_nx   = pend_dp;
        pend_bl_nx   = pend_bl;
        pend_flag_nx = pend_flag;

        // A load coinciding with the wrap bypasses the pending set entirely.
        if (bus.load_valid) begin
            if (wrap) begin
                act_dig_nx   = bus.digits_in;
                act_dp_nx    = bus.dp_in;
                act_bl_nx    = bus.blink_in;
                pend_flag_nx = 1'b0;
            end else begin
                pend_dig_nx  = bus.digits_in;
                pend_dp_nx   = bus.dp_in;
                pend_bl_nx   = bus.blink_in;
                pend_flag_nx = 1'b1;
            end
        end else if (wrap && pend_flag) begin
            act_dig_nx   = pend_dig;
            act_dp_nx    = pend_dp;
            act_bl_nx    = pend_bl;
            pend_flag_nx = 1'b0;
        end

        // Outputs are registered, so they are derived from the next-state
        // position and active set to keep one cycle of latency.
        digit  = act_dig_nx[{pos_nx, 2'b00} +: 4];
        blank  = act_bl_nx[pos_nx] && clk_blink;
        an_nx  = blank ? '1 : ~(4'b0001 << pos_nx);
        seg_nx = blank ? '1 : {~act_dp_nx[pos_nx], hex7(digit)};
    end

    always_ff @(posedge master_clk) begin
        if (rst) begin
            pos         <= '0;
            act_dig     <= '0;
            act_dp      <= '0;
            act_bl      <= '0;
            pend_dig    <= '0;
            pend_dp     <= '0;
            pend_bl     <= '0;
            pend_flag   <= 1'b0;
            bus.an      <= '1;
            bus.seg     <= '1;
            frame_start <= 1'b0;
        end else begin
            pos         <= pos_nx;
            act_dig     <= act_dig_nx;
            act_dp      <= act_dp_nx;
            act_bl      <= act_bl_nx;
            pend_dig    <= pend_dig_nx;
            pend_dp     <= pend_dp_nx;
            pend_bl     <= pend_bl_nx;
            pend_flag   <= pend_flag_nx;
            bus.an      <= an_nx;
            bus.seg     <= seg_nx;
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
//   Self-checking bench for seven_seg_scanner. A behavioural model predicts
//   {an, seg, frame_start} for every clock; predictions and observed outputs
//   are queued per cycle and drained by each scenario task.
module tb_seven_seg_scanner;

    logic master_clk = 1'b0;
    logic rst;
    logic clk_display;
    logic clk_blink;
    logic frame_start;

    seven_seg_scanner_if bus();

    seven_seg_scanner #(.NUM_DIGITS(4)) dut (
        .master_clk  (master_clk),
        .rst         (rst),
        .clk_display (clk_display),
        .clk_blink   (clk_blink),
        .bus         (bus),
        .frame_start (frame_start)
    );

    always #5 master_clk = ~master_clk;

    localparam logic [6:0] HEX_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    logic [12:0] exp_q[$];
    logic [12:0] got_q[$];

    // reference model state
    logic [1:0]  m_pos;
    logic [15:0] m_dig, p_dig;
    logic [3:0]  m_dp, m_bl, p_dp, p_bl;
    logic        m_flag;

    task automatic model_step();
        logic       is_wrap;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic [3:0] nib;
        if (rst) begin
            m_pos = 0; m_dig = 0; m_dp = 0; m_bl = 0;
            p_dig = 0; p_dp = 0; p_bl = 0; m_flag = 0;
            exp_q.push_back({4'hF, 8'hFF, 1'b0});
        end else begin
            is_wrap = clk_display && (m_pos == 2'd3);
            if (clk_display) m_pos = m_pos + 2'd1;
            if (bus.load_valid && is_wrap) begin
                m_dig = bus.digits_in; m_dp = bus.dp_in; m_bl = bus.blink_in; m_flag = 0;
            end else if (bus.load_valid) begin
                p_dig = bus.digits_in; p_dp = bus.dp_in; p_bl = bus.blink_in; m_flag = 1;
            end else if (is_wrap && m_flag) begin
                m_dig = p_dig; m_dp = p_dp; m_bl = p_bl; m_flag = 0;
            end
            nib = m_dig[int'(m_pos) * 4 +: 4];
            if (m_bl[m_pos] && clk_blink) begin
                e_an = 4'hF; e_seg = 8'hFF;
            end else begin
                e_an = ~(4'b0001 << m_pos);
                e_seg = {~m_dp[m_pos], HEX_LUT[nib]};
            end
            exp_q.push_back({e_an, e_seg, is_wrap});
        end
    endtask

    task automatic cyc();
        @(posedge master_clk);
        model_step();
        #1;
        got_q.push_back({bus.an, bus.seg, frame_start});
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) cyc();
    endtask

    task automatic tick();
        clk_display = 1'b1;
        cyc();
        clk_display = 1'b0;
    endtask

    task automatic tick_to(input logic [1:0] p);
        for (int unsigned i = 0; i < 4 && m_pos != p; i++) tick();
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        bus.digits_in  = d;
        bus.dp_in      = dp;
        bus.blink_in   = bl;
        bus.load_valid = 1'b1;
        cyc();
        bus.load_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] e, g;
        rst = 1'b1;
        idle(3);
        n_cmp++;
        if (bus.an !== 4'hF || bus.seg !== 8'hFF) begin
            n_mis++; $display("FAIL reset_hold: an=%b seg=%h, required an=1111 seg=ff", bus.an, bus.seg);
        end
        rst = 1'b0;
        cyc();
        n_cmp++;
        if (bus.an !== 4'b1110 || bus.seg !== 8'hC0 || frame_start !== 1'b0) begin
            n_mis++; $display("FAIL reset_release: an=%b seg=%h fs=%b, required an=1110 seg=c0 fs=0", bus.an, bus.seg, frame_start);
        end
        idle(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_mis++; $display("FAIL reset_trace: {an,seg,fs}=%b, required %b", g, e); end
        end
    endtask

    task automatic test_scan();
        logic [12:0] e, g;
        logic [7:0]  scan_seg [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        int unsigned fs_cnt = 0;
        int unsigned p;
        load(16'h1234, 4'h0, 4'h0);
        for (int unsigned k = 1; k <= 8; k++) begin
            tick();
            if (k >= 4) begin
                p = k % 4;
                n_cmp++;
                if (bus.an !== ~(4'b0001 << p) || bus.seg !== scan_seg[p]) begin
                    n_mis++; $display("FAIL scan_tick%0d: an=%b seg=%h, required an=%b seg=%h", k, bus.an, bus.seg, ~(4'b0001 << p), scan_seg[p]);
                end
            end
            idle(4);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            fs_cnt += g[0];
            if (g !== e) begin n_mis++; $display("FAIL scan_trace: {an,seg,fs}=%b, required %b", g, e); end
        end
        n_cmp++;
        if (fs_cnt != 2) begin n_mis++; $display("FAIL scan_frame_start: pulses=%0d, required 2", fs_cnt); end
    endtask

    task automatic test_frame_coherence();
        logic [12:0] e, g;
        int unsigned bad = 0;
        tick_to(2'd1);
        load(16'hAAAA, 4'h0, 4'h0);
        tick_to(2'd2);
        load(16'h5555, 4'h0, 4'h0);
        tick_to(2'd3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g[8:1] == 8'h88 || g[8:1] == 8'h92) bad++;
            if (g !== e) begin n_mis++; $display("FAIL coherence_pre: {an,seg,fs}=%b, required %b", g, e); end
        end
        n_cmp++;
        if (bad != 0) begin n_mis++; $display("FAIL coherence_early: early/mixed digits seen=%0d, required 0", bad); end
        tick();
        n_cmp++;
        if (bus.an !== 4'b1110 || bus.seg !== 8'h92) begin
            n_mis++; $display("FAIL coherence_commit: an=%b seg=%h, required an=1110 seg=92", bus.an, bus.seg);
        end
        for (int unsigned k = 0; k < 4; k++) begin tick(); idle(1); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g[8:1] == 8'h88) bad++;
            if (g !== e) begin n_mis++; $display("FAIL coherence_post: {an,seg,fs}=%b, required %b", g, e); end
        end
        n_cmp++;
        if (bad != 0) begin n_mis++; $display("FAIL coherence_no_A: A digits seen=%0d, required 0", bad); end
    endtask

    task automatic test_simul_load_wrap();
        logic [12:0] e, g;
        tick_to(2'd1);
        load(16'h7777, 4'h0, 4'h0);
        tick_to(2'd3);
        bus.digits_in  = 16'h000F;
        bus.dp_in      = 4'h0;
        bus.blink_in   = 4'h0;
        bus.load_valid = 1'b1;
        clk_display    = 1'b1;
        cyc();
        bus.load_valid = 1'b0;
        clk_display    = 1'b0;
        n_cmp++;
        if (bus.an !== 4'b1110 || bus.seg !== 8'h8E || frame_start !== 1'b1) begin
            n_mis++; $display("FAIL simul_commit: an=%b seg=%h fs=%b, required an=1110 seg=8e fs=1", bus.an, bus.seg, frame_start);
        end
        tick_to(2'd3);
        tick();
        n_cmp++;
        if (bus.an !== 4'b1110 || bus.seg !== 8'h8E) begin
            n_mis++; $display("FAIL simul_flag_clear: an=%b seg=%h, required an=1110 seg=8e", bus.an, bus.seg);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_mis++; $display("FAIL simul_trace: {an,seg,fs}=%b, required %b", g, e); end
        end
    endtask

    task automatic test_blink();
        logic [12:0] e, g;
        load(16'h0008, 4'b0001, 4'b0001);
        tick_to(2'd3);
        tick();
        n_cmp++;
        if (bus.an !== 4'b1110 || bus.seg !== 8'h00) begin
            n_mis++; $display("FAIL blink_commit: an=%b seg=%h, required an=1110 seg=00", bus.an, bus.seg);
        end
        clk_blink = 1'b1;
        cyc();
        n_cmp++;
        if (bus.an !== 4'hF || bus.seg !== 8'hFF) begin
            n_mis++; $display("FAIL blink_on: an=%b seg=%h, required an=1111 seg=ff", bus.an, bus.seg);
        end
        clk_blink = 1'b0;
        cyc();
        n_cmp++;
        if (bus.an !== 4'b1110 || bus.seg !== 8'h00) begin
            n_mis++; $display("FAIL blink_off: an=%b seg=%h, required an=1110 seg=00", bus.an, bus.seg);
        end
        clk_blink = 1'b1;
        tick();
        n_cmp++;
        if (bus.an !== 4'b1101 || bus.seg !== 8'hC0) begin
            n_mis++; $display("FAIL blink_unmasked: an=%b seg=%h, required an=1101 seg=c0", bus.an, bus.seg);
        end
        clk_blink = 1'b0;
        idle(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_mis++; $display("FAIL blink_trace: {an,seg,fs}=%b, required %b", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] e, g;
        int unsigned fs_cnt = 0;
        clk_display = 1'b1;
        idle(5);
        clk_display = 1'b0;
        n_cmp++;
        if (bus.an !== 4'b1011 || bus.seg !== 8'hC0) begin
            n_mis++; $display("FAIL b2b_final: an=%b seg=%h, required an=1011 seg=c0", bus.an, bus.seg);
        end
        idle(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            fs_cnt += g[0];
            if (g !== e) begin n_mis++; $display("FAIL b2b_trace: {an,seg,fs}=%b, required %b", g, e); end
        end
        n_cmp++;
        if (fs_cnt != 1) begin n_mis++; $display("FAIL b2b_frame_start: pulses=%0d, required 1", fs_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [12:0] e, g;
        int unsigned leak = 0;
        tick_to(2'd2);
        load(16'h9999, 4'hF, 4'h0);
        rst = 1'b1;
        idle(2);
        n_cmp++;
        if (bus.an !== 4'hF || bus.seg !== 8'hFF) begin
            n_mis++; $display("FAIL midrst_hold: an=%b seg=%h, required an=1111 seg=ff", bus.an, bus.seg);
        end
        rst = 1'b0;
        cyc();
        n_cmp++;
        if (bus.an !== 4'b1110 || bus.seg !== 8'hC0) begin
            n_mis++; $display("FAIL midrst_release: an=%b seg=%h, required an=1110 seg=c0", bus.an, bus.seg);
        end
        for (int unsigned k = 0; k < 8; k++) begin tick(); idle(1); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g[8:1] != 8'hC0 && g[8:1] != 8'hFF) leak++;
            if (g !== e) begin n_mis++; $display("FAIL midrst_trace: {an,seg,fs}=%b, required %b", g, e); end
        end
        n_cmp++;
        if (leak != 0) begin n_mis++; $display("FAIL midrst_pending_shown: cycles=%0d, required 0", leak); end
    endtask

    initial begin
        rst            = 1'b1;
        clk_display    = 1'b0;
        clk_blink      = 1'b0;
        bus.load_valid = 1'b0;
        bus.digits_in  = '0;
        bus.dp_in      = '0;
        bus.blink_in   = '0;
        test_reset();
        test_scan();
        test_frame_coherence();
        test_simul_load_wrap();
        test_blink();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
